// File: rtl/rv32_irq_ctrl.sv
// ---------------------------------------------------------------------------
// rv32_irq_ctrl
//   Multi-source interrupt controller for the RV32 core. It collects NUM_SRC
//   prioritised sources (per-source enable, priority, edge/level mode, pending
//   bit, global threshold) into a single registered irq_o. The interrupt is
//   served through a claim/complete handshake, and only one interrupt can be
//   outstanding at a time (no nesting).
//
// Ports
//   clk, rst_n      core clock, asynchronous active-low reset
//   src_i           interrupt sources, bit i is source ID i+1
//   cfg_we/addr/    config write strobe, word address, write data
//   cfg_wdata
//   cfg_rdata       config read data, combinational from cfg_addr
//   irq_o           registered interrupt request to the core
//   claim_i         claim pulse; claim_id_o returns the claimed ID (0 = none)
//   complete_i,     completion pulse with the ID being completed
//   complete_id
//
// Register map (word addresses)
//   0x00 ENABLE  0x01 MODE (1=edge)  0x02 PENDING (W1C)  0x03 THRESHOLD
//   0x04+i PRIO of source ID i+1
// ---------------------------------------------------------------------------
module rv32_irq_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3,
    parameter int ID_W    = $clog2(NUM_SRC + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               cfg_we,
    input  logic [5:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               irq_o,
    input  logic               claim_i,
    output logic [ID_W-1:0]    claim_id_o,
    input  logic               complete_i,
    input  logic [ID_W-1:0]    complete_id
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_SERVICE
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] pending;
    logic [PRIO_W-1:0]  threshold;
    logic [PRIO_W-1:0]  prio [NUM_SRC];

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] claimed;
    logic [NUM_SRC-1:0] w1c;
    logic [ID_W-1:0]    winner_id;
    logic [PRIO_W-1:0]  winner_prio;
    logic               any_eligible;
    logic               claim_fire;

    // Upper write-data bits are architecturally ignored.
    logic [31:0]        unused_wdata;
    assign unused_wdata = cfg_wdata;

    // Priority resolution: strict '>' while scanning upward keeps ties on the
    // lowest ID. Eligible sources always have PRIO > THRESHOLD >= 0, so a
    // starting best priority of 0 never hides a real candidate.
    always_comb begin
        eligible    = '0;
        in_service  = '0;
        winner_id   = '0;
        winner_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i]   = pending[i] & enable[i] & (prio[i] > threshold);
            in_service[i] = (state == S_SERVICE) && (claim_id_o == ID_W'(i + 1));
            if (eligible[i] && (prio[i] > winner_prio)) begin
                winner_prio = prio[i];
                winner_id   = ID_W'(i + 1);
            end
        end
    end

    assign any_eligible = |eligible;
    assign claim_fire   = (state == S_ASSERT) && claim_i && any_eligible;
    assign w1c          = {NUM_SRC{cfg_we && (cfg_addr == 6'd2)}} & cfg_wdata[NUM_SRC-1:0];

    always_comb begin
        claimed = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claimed[i] = claim_fire && (winner_id == ID_W'(i + 1));
        end
    end

    // Pending tracking. The in-service source freezes its bit so a repeat
    // edge during service is not queued behind itself. In edge mode a new
    // edge overrides a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= '0;
            pending <= '0;
        end else begin
            src_q <= src_i;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!in_service[i]) begin
                    if (mode[i]) begin
                        pending[i] <= (src_i[i] & ~src_q[i]) |
                                      (pending[i] & ~(w1c[i] | claimed[i]));
                    end else begin
                        pending[i] <= src_i[i];
                    end
                end
            end
        end
    end

    // Configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable    <= '0;
            mode      <= '0;
            threshold <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                prio[i] <= '0;
            end
        end else if (cfg_we) begin
            case (cfg_addr)
                6'd0:    enable    <= cfg_wdata[NUM_SRC-1:0];
                6'd1:    mode      <= cfg_wdata[NUM_SRC-1:0];
                6'd3:    threshold <= cfg_wdata[PRIO_W-1:0];
                default: ;
            endcase
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cfg_addr == 6'(4 + i)) begin
                    prio[i] <= cfg_wdata[PRIO_W-1:0];
                end
            end
        end
    end

    // Claim/complete FSM. irq_o is held low in SERVICE so only one interrupt
    // is ever outstanding; disabling or re-prioritising the in-service
    // source does not end service, only a matching complete does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            irq_o      <= 1'b0;
            claim_id_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_eligible) begin
                        state <= S_ASSERT;
                        irq_o <= 1'b1;
                    end
                end
                S_ASSERT: begin
                    if (!any_eligible) begin
                        state <= S_IDLE;
                        irq_o <= 1'b0;
                    end else if (claim_i) begin
                        state      <= S_SERVICE;
                        irq_o      <= 1'b0;
                        claim_id_o <= winner_id;
                    end
                end
                S_SERVICE: begin
                    if (complete_i && (complete_id == claim_id_o)) begin
                        state      <= S_IDLE;
                        claim_id_o <= '0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    irq_o      <= 1'b0;
                    claim_id_o <= '0;
                end
            endcase
        end
    end

    // Config read mux; unmapped addresses read as zero.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            6'd0:    cfg_rdata[NUM_SRC-1:0] = enable;
            6'd1:    cfg_rdata[NUM_SRC-1:0] = mode;
            6'd2:    cfg_rdata[NUM_SRC-1:0] = pending;
            6'd3:    cfg_rdata[PRIO_W-1:0]  = threshold;
            default: ;
        endcase
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cfg_addr == 6'(4 + i)) begin
                cfg_rdata[PRIO_W-1:0] = prio[i];
            end
        end
    end

endmodule

// File: tb/tb_rv32_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32_irq_ctrl
//   Drives rv32_irq_ctrl with directed scenarios and a randomized phase. A
//   behavioural model predicts irq_o, claim_id_o and cfg_rdata each cycle;
//   predictions are queued and a monitor compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_rv32_irq_ctrl;

    localparam int NUM_SRC = 8;
    localparam int PRIO_W  = 3;
    localparam int ID_W    = $clog2(NUM_SRC + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_SRC-1:0] src_i = '0;
    logic               cfg_we = 1'b0;
    logic [5:0]         cfg_addr = '0;
    logic [31:0]        cfg_wdata = '0;
    logic [31:0]        cfg_rdata;
    logic               irq_o;
    logic               claim_i = 1'b0;
    logic [ID_W-1:0]    claim_id_o;
    logic               complete_i = 1'b0;
    logic [ID_W-1:0]    complete_id = '0;

    rv32_irq_ctrl #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_i       (src_i),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (cfg_rdata),
        .irq_o       (irq_o),
        .claim_i     (claim_i),
        .claim_id_o  (claim_id_o),
        .complete_i  (complete_i),
        .complete_id (complete_id)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic            irq;
        logic [ID_W-1:0] cid;
        logic [31:0]     rd;
    } exp_t;

    exp_t sb[$];

    // ---------------- behavioural model ----------------
    bit [NUM_SRC-1:0] m_en, m_mode, m_pend, m_srcq;
    int               m_thr;
    int               m_prio [NUM_SRC];
    int               m_served;   // ID currently being served, 0 = none
    bit               m_irq;

    function automatic void m_reset();
        m_en = '0; m_mode = '0; m_pend = '0; m_srcq = '0;
        m_thr = 0; m_served = 0; m_irq = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) m_prio[i] = 0;
    endfunction

    function automatic int m_winner();
        int best = 0;
        int bp   = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (m_pend[i] && m_en[i] && m_prio[i] > m_thr && m_prio[i] > bp) begin
                bp   = m_prio[i];
                best = i + 1;
            end
        end
        return best;
    endfunction

    function automatic logic [31:0] m_read(int a);
        logic [31:0] r = '0;
        if (a == 0)      r[NUM_SRC-1:0] = m_en;
        else if (a == 1) r[NUM_SRC-1:0] = m_mode;
        else if (a == 2) r[NUM_SRC-1:0] = m_pend;
        else if (a == 3) r = 32'(m_thr);
        else if (a >= 4 && a < 4 + NUM_SRC) r = 32'(m_prio[a - 4]);
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void m_clock();
        int w;
        int old_served;
        int claimed;
        int a;
        if (!rst_n) begin
            m_reset();
            return;
        end
        w          = m_winner();
        old_served = m_served;
        claimed    = 0;
        a          = int'(cfg_addr);
        if (old_served != 0) begin
            m_irq = 1'b0;
            if (complete_i && int'(complete_id) == old_served) m_served = 0;
        end else if (m_irq) begin
            if (w == 0) m_irq = 1'b0;
            else if (claim_i) begin
                claimed  = w;
                m_served = w;
                m_irq    = 1'b0;
            end
        end else begin
            m_irq = (w != 0);
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (old_served != i + 1) begin
                if (m_mode[i]) begin
                    bit set = src_i[i] && !m_srcq[i];
                    bit clr = (cfg_we && a == 2 && cfg_wdata[i]) || (claimed == i + 1);
                    m_pend[i] = set || (m_pend[i] && !clr);
                end else begin
                    m_pend[i] = src_i[i];
                end
            end
        end
        if (cfg_we) begin
            if (a == 0) m_en = cfg_wdata[NUM_SRC-1:0];
            if (a == 1) m_mode = cfg_wdata[NUM_SRC-1:0];
            if (a == 3) m_thr = int'(cfg_wdata[PRIO_W-1:0]);
            if (a >= 4 && a < 4 + NUM_SRC) m_prio[a - 4] = int'(cfg_wdata[PRIO_W-1:0]);
        end
        m_srcq = src_i;
    endfunction

    // ---------------- checking ----------------
    task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks += 3;
                if (irq_o !== e.irq) begin
                    errors++;
                    $display("FAIL sb_irq: got %0b expected %0b at %0t", irq_o, e.irq, $time);
                end
                if (claim_id_o !== e.cid) begin
                    errors++;
                    $display("FAIL sb_claim_id: got %0d expected %0d at %0t", claim_id_o, e.cid, $time);
                end
                if (cfg_rdata !== e.rd) begin
                    errors++;
                    $display("FAIL sb_rdata[addr %0d]: got 0x%0h expected 0x%0h at %0t",
                             cfg_addr, cfg_rdata, e.rd, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    // One clock cycle: queue the prediction for the current state and read
    // address, take the edge, advance the model, then drop pulse inputs.
    task automatic cyc();
        sb.push_back('{m_irq, ID_W'(m_served), m_read(int'(cfg_addr))});
        @(posedge clk);
        m_clock();
        #1;
        claim_i    = 1'b0;
        complete_i = 1'b0;
        cfg_we     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = 6'(a);
        cfg_wdata = d;
        cyc();
    endtask

    task automatic do_claim();
        claim_i = 1'b1;
        cyc();
    endtask

    task automatic do_complete(input int id);
        complete_i  = 1'b1;
        complete_id = ID_W'(id);
        cyc();
    endtask

    task automatic pulse_src(input logic [NUM_SRC-1:0] v);
        src_i = v;
        cyc();
        src_i = '0;
    endtask

    // ---------------- main sequence ----------------
    initial begin : driver
        m_reset();
        @(posedge clk);
        #1;
        idle(2);
        rst_n = 1'b1;

        // Reset state at every address.
        dchk("rst_irq", 32'(irq_o), 32'd0);
        dchk("rst_claim_id", 32'(claim_id_o), 32'd0);
        for (int a = 0; a < 64; a++) begin
            cfg_addr = 6'(a);
            cyc();
        end

        // Single edge source ID 3 through claim/complete.
        wr(0, 32'h04); wr(1, 32'h04); wr(6, 32'd5); wr(3, 32'd2);
        pulse_src(8'h04);
        cfg_addr = 6'd2;
        cyc();
        dchk("t2_irq_up", 32'(irq_o), 32'd1);
        do_claim();
        dchk("t2_claim_id", 32'(claim_id_o), 32'd3);
        dchk("t2_pend_clr", cfg_rdata, 32'd0);
        do_complete(3);
        dchk("t2_complete", 32'(claim_id_o), 32'd0);

        // Level sources 1 and 4: priority then tie-break by lowest ID.
        wr(0, 32'h09); wr(1, 32'h00); wr(4, 32'd3); wr(7, 32'd6);
        src_i = 8'h09;
        idle(3);
        do_claim();
        dchk("t3_prio_win", 32'(claim_id_o), 32'd4);
        do_complete(4);
        wr(4, 32'd6);
        idle(3);
        do_claim();
        dchk("t3_tie_win", 32'(claim_id_o), 32'd1);
        do_complete(1);
        src_i = '0;
        idle(3);
        wr(0, 32'h00);

        // Threshold gating.
        wr(1, 32'h04); wr(6, 32'd6); wr(3, 32'd6); wr(0, 32'h04);
        pulse_src(8'h04);
        idle(3);
        dchk("t4_thr_block", 32'(irq_o), 32'd0);
        wr(3, 32'd5);
        dchk("t4_thr_lat1", 32'(irq_o), 32'd0);
        cyc();
        dchk("t4_thr_lat2", 32'(irq_o), 32'd1);

        // Service behaviour: mismatched complete, edges during service.
        do_claim();
        dchk("t5_claim", 32'(claim_id_o), 32'd3);
        do_complete(2);
        dchk("t5_bad_cmp_irq", 32'(irq_o), 32'd0);
        dchk("t5_bad_cmp_id", 32'(claim_id_o), 32'd3);
        pulse_src(8'h04);
        cfg_addr = 6'd2;
        cyc();
        dchk("t5_no_repend", cfg_rdata, 32'd0);
        wr(0, 32'h14); wr(1, 32'h14); wr(8, 32'd7);
        pulse_src(8'h10);
        cfg_addr = 6'd2;
        cyc();
        dchk("t5_id5_pend", cfg_rdata, 32'h10);
        dchk("t5_irq_held", 32'(irq_o), 32'd0);
        do_complete(3);
        cyc();
        dchk("t5_irq_after", 32'(irq_o), 32'd1);

        // Edge coinciding with W1C, then reset during service.
        do_claim();
        dchk("t6_claim5", 32'(claim_id_o), 32'd5);
        do_complete(5);
        src_i     = 8'h10;
        cfg_we    = 1'b1;
        cfg_addr  = 6'd2;
        cfg_wdata = 32'h10;
        cyc();
        src_i    = '0;
        cfg_addr = 6'd2;
        cyc();
        dchk("t6_set_wins", cfg_rdata, 32'h10);
        do_claim();
        dchk("t6_claim_again", 32'(claim_id_o), 32'd5);
        rst_n = 1'b0;
        m_reset();
        #1;
        dchk("t6_async_irq", 32'(irq_o), 32'd0);
        dchk("t6_async_id", 32'(claim_id_o), 32'd0);
        dchk("t6_async_pend", cfg_rdata, 32'd0);
        idle(2);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(3) == 0) src_i = NUM_SRC'($urandom);
            if ($urandom_range(5) == 0) begin
                cfg_we    = 1'b1;
                cfg_addr  = 6'($urandom_range(13));
                cfg_wdata = $urandom;
            end else begin
                cfg_addr = 6'($urandom_range(63));
            end
            claim_i = ($urandom_range(3) == 0);
            if ($urandom_range(4) == 0) begin
                complete_i  = 1'b1;
                complete_id = ($urandom_range(1) == 1) ? ID_W'(m_served)
                                                       : ID_W'($urandom_range(NUM_SRC));
            end
            cyc();
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
